// File: rtl/mining_pkg.sv
// Shared types and helpers for the mining lane controller: FSM state encoding,
// default geometry and the hash-versus-target compare.
package mining_pkg;

  localparam int DEF_LANES    = 3;
  localparam int DEF_NONCE_W  = 32;
  localparam int DEF_HASH_W   = 24;
  localparam int DEF_TARGET_W = 8;

  // Widest target the compare helper accepts; callers zero-extend into it.
  localparam int CMP_W = 64;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    WAIT    = 3'd2,
    CHECK   = 3'd3,
    DONE    = 3'd4,
    EXHAUST = 3'd5
  } state_e;

  // A target of 0 can never hit because nothing is below it.
  function automatic logic hash_hits(input logic [CMP_W-1:0] hash_msb,
                                     input logic [CMP_W-1:0] tgt);
    return hash_msb < tgt;
  endfunction

endpackage

// File: rtl/lane_prio_enc.sv
// Lowest-set-bit priority encoder over the lane hit mask, plus an any-bit flag.
// Lane index order equals nonce order, so the lowest index is the lowest nonce.
module lane_prio_enc #(
  parameter int LANES = 3,
  localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic [LANES-1:0] mask_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  always_comb begin
    idx_o = '0;
    any_o = 1'b0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (mask_i[i]) begin
        idx_o = IDX_W'(i);
        any_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mining_lane_ctrl.sv
// Interleaved nonce dispatcher / result collector for LANES hash lanes.
// Optional LANE_TIMEOUT_EN adds a WAIT watchdog (TIMEOUT) and a sticky timeout_err.
module mining_lane_ctrl
  import mining_pkg::*;
#(
  parameter int LANES    = DEF_LANES,
  parameter int NONCE_W  = DEF_NONCE_W,
  parameter int HASH_W   = DEF_HASH_W,
  parameter int TARGET_W = DEF_TARGET_W
`ifdef LANE_TIMEOUT_EN
  , parameter int TIMEOUT = 64
`endif
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [TARGET_W-1:0]      target,
  output logic [LANES*NONCE_W-1:0] lane_nonce,
  output logic                     lane_go,
  input  logic [LANES-1:0]         lane_valid,
  input  logic [LANES*HASH_W-1:0]  lane_hash,
  output logic                     busy,
  output logic                     finished,
  output logic [NONCE_W-1:0]       nonce_out,
  output logic                     exhausted,
`ifdef LANE_TIMEOUT_EN
  output logic                     timeout_err,
`endif
  output state_e                   dbg_state
);

  localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [NONCE_W:0] NONCE_MAX = {1'b0, {NONCE_W{1'b1}}};

  state_e                   state_q;
  logic [NONCE_W-1:0]       base_q;
  logic [TARGET_W-1:0]      target_q;
  logic [LANES-1:0]         done_q, hit_q;
  logic [LANES*NONCE_W-1:0] lane_nonce_q;
  logic                     go_q, finished_q, exhausted_q;
  logic [NONCE_W-1:0]       nonce_out_q;

  logic [LANES-1:0]   lane_en, lane_hit, done_d, hit_d;
  logic [NONCE_W:0]   next_span;
  logic [NONCE_W-1:0] base_next;
  logic               base_last, start_ok, tmo_fire, hit_any;
  logic [IDX_W-1:0]   hit_idx;
  logic               unused_hash;

  // Lane handshake: lane_go pulses once per batch with lane_nonce already stable;
  // each lane answers with exactly one lane_valid strobe carrying lane_hash. Strobes
  // seen during ISSUE, or repeated for an already-done lane, are dropped.

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic [NONCE_W:0] sum;
    assign sum         = {1'b0, base_q} + (NONCE_W+1)'(g);
    assign lane_en[g]  = (sum <= NONCE_MAX);
    assign lane_hit[g] = hash_hits(CMP_W'(lane_hash[g*HASH_W + HASH_W - TARGET_W +: TARGET_W]),
                                   CMP_W'(target_q));
  end

  assign unused_hash = ^lane_hash;
  assign next_span   = {1'b0, base_q} + (NONCE_W+1)'(LANES);
  assign base_last   = (next_span > NONCE_MAX);
  assign base_next   = base_q + NONCE_W'(LANES);
  assign done_d      = done_q | lane_valid;
  assign hit_d       = hit_q | (lane_valid & ~done_q & lane_hit);
  assign start_ok    = start && (state_q == IDLE || state_q == DONE || state_q == EXHAUST);

  lane_prio_enc #(.LANES(LANES)) u_prio (
    .mask_i (hit_q),
    .idx_o  (hit_idx),
    .any_o  (hit_any)
  );

  // Slices for a batch starting at b; lanes past the top of the nonce space read 0.
  function automatic logic [LANES*NONCE_W-1:0] slices_for(input logic [NONCE_W-1:0] b);
    logic [NONCE_W:0] n;
    slices_for = '0;
    for (int i = 0; i < LANES; i++) begin
      n = {1'b0, b} + (NONCE_W+1)'(i);
      if (n <= NONCE_MAX) slices_for[i*NONCE_W +: NONCE_W] = n[NONCE_W-1:0];
    end
  endfunction

`ifdef LANE_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_q;
  logic             timeout_err_q;

  assign tmo_fire = (state_q == WAIT) && (cnt_q == CNT_W'(TIMEOUT - 1)) && !(&done_d);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q         <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      if (state_q == ISSUE)     cnt_q <= '0;
      else if (state_q == WAIT) cnt_q <= cnt_q + CNT_W'(1);
      if (start_ok)             timeout_err_q <= 1'b0;
      else if (tmo_fire)        timeout_err_q <= 1'b1;
    end
  end

  assign timeout_err = timeout_err_q;
`else
  assign tmo_fire = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      base_q       <= '0;
      target_q     <= '0;
      done_q       <= '0;
      hit_q        <= '0;
      lane_nonce_q <= '0;
      go_q         <= 1'b0;
      finished_q   <= 1'b0;
      exhausted_q  <= 1'b0;
      nonce_out_q  <= '0;
    end else begin
      go_q <= 1'b0;
      case (state_q)
        IDLE, DONE, EXHAUST: begin
          if (start_ok) begin
            state_q      <= ISSUE;
            base_q       <= '0;
            target_q     <= target;
            lane_nonce_q <= slices_for('0);
            go_q         <= 1'b1;
            finished_q   <= 1'b0;
            exhausted_q  <= 1'b0;
            nonce_out_q  <= '0;
          end
        end
        ISSUE: begin
          done_q  <= ~lane_en;
          hit_q   <= '0;
          state_q <= WAIT;
        end
        WAIT: begin
          done_q <= done_d;
          hit_q  <= hit_d;
          if ((&done_d) || tmo_fire) state_q <= CHECK;
        end
        CHECK: begin
          if (hit_any) begin
            nonce_out_q <= base_q + NONCE_W'(hit_idx);
            finished_q  <= 1'b1;
            state_q     <= DONE;
          end else if (base_last) begin
            exhausted_q <= 1'b1;
            state_q     <= EXHAUST;
          end else begin
            base_q       <= base_next;
            lane_nonce_q <= slices_for(base_next);
            go_q         <= 1'b1;
            state_q      <= ISSUE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign lane_nonce = lane_nonce_q;
  assign lane_go    = go_q;
  assign busy       = (state_q == ISSUE) || (state_q == WAIT) || (state_q == CHECK);
  assign finished   = finished_q;
  assign exhausted  = exhausted_q;
  assign nonce_out  = nonce_out_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_mining_lane_ctrl.sv
// Directed bench for mining_lane_ctrl: a default 32-bit instance plus a 4-bit-nonce
// instance sharing the same lane stimulus; the watchdog scenario needs LANE_TIMEOUT_EN.
module tb_mining_lane_ctrl;
  import mining_pkg::*;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [7:0]  target;
  logic [2:0]  lane_valid;
  logic [71:0] lane_hash;

  logic [95:0] lane_nonce;
  logic        lane_go, busy, finished, exhausted;
  logic [31:0] nonce_out;
  state_e      dbg_state;

  logic [11:0] lane_nonce4;
  logic        lane_go4, busy4, finished4, exhausted4;
  logic [3:0]  nonce_out4;
  state_e      dbg_state4;

  int tests_run = 0;
  int tests_failed = 0;
  int go_cnt = 0;
  int go_cnt4 = 0;

`ifdef LANE_TIMEOUT_EN
  logic timeout_err, timeout_err4;
  mining_lane_ctrl #(.TIMEOUT(8)) dut (
    .clk(clk), .reset(reset), .start(start), .target(target),
    .lane_nonce(lane_nonce), .lane_go(lane_go), .lane_valid(lane_valid), .lane_hash(lane_hash),
    .busy(busy), .finished(finished), .nonce_out(nonce_out), .exhausted(exhausted),
    .timeout_err(timeout_err), .dbg_state(dbg_state));
  mining_lane_ctrl #(.LANES(3), .NONCE_W(4)) dut4 (
    .clk(clk), .reset(reset), .start(start), .target(target),
    .lane_nonce(lane_nonce4), .lane_go(lane_go4), .lane_valid(lane_valid), .lane_hash(lane_hash),
    .busy(busy4), .finished(finished4), .nonce_out(nonce_out4), .exhausted(exhausted4),
    .timeout_err(timeout_err4), .dbg_state(dbg_state4));
`else
  mining_lane_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .target(target),
    .lane_nonce(lane_nonce), .lane_go(lane_go), .lane_valid(lane_valid), .lane_hash(lane_hash),
    .busy(busy), .finished(finished), .nonce_out(nonce_out), .exhausted(exhausted),
    .dbg_state(dbg_state));
  mining_lane_ctrl #(.LANES(3), .NONCE_W(4)) dut4 (
    .clk(clk), .reset(reset), .start(start), .target(target),
    .lane_nonce(lane_nonce4), .lane_go(lane_go4), .lane_valid(lane_valid), .lane_hash(lane_hash),
    .busy(busy4), .finished(finished4), .nonce_out(nonce_out4), .exhausted(exhausted4),
    .dbg_state(dbg_state4));
`endif

  // Clock / reset
  initial forever #5 clk = ~clk;

  always @(negedge clk) begin
    if (lane_go)  go_cnt++;
    if (lane_go4) go_cnt4++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached (got timeout, expected completion)");
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic drive_start(input logic [7:0] tgt);
    @(posedge clk); #1; start = 1'b1; target = tgt;
    @(posedge clk); #1; start = 1'b0;
  endtask

  task automatic wait_go(input bit which);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 64 && !seen; i++) begin
      @(negedge clk);
      seen = which ? lane_go4 : lane_go;
    end
    tests_run++;
    if (!seen) begin
      tests_failed++;
      $display("FAIL wait_go%0d: lane_go got 0 within 64 cycles, expected 1", which);
    end
  endtask

  // Lane i answers d_i cycles after the go cycle; d_i == 0 means never.
  task automatic drive_batch(input logic [7:0] m0, m1, m2, input int d0, d1, d2);
    int dmax;
    dmax = d0;
    if (d1 > dmax) dmax = d1;
    if (d2 > dmax) dmax = d2;
    lane_hash = {m2, 16'h0, m1, 16'h0, m0, 16'h0};
    for (int k = 1; k <= dmax; k++) begin
      @(posedge clk); #1;
      lane_valid = {d2 == k, d1 == k, d0 == k};
    end
    @(posedge clk); #1;
    lane_valid = '0;
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    tests_run++;
    if ({lane_nonce, lane_go, busy, finished, nonce_out, exhausted} !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got nonce=%0h go=%0b busy=%0b fin=%0b nout=%0h exh=%0b, expected all 0",
               lane_nonce, lane_go, busy, finished, nonce_out, exhausted);
    end
    tests_run++;
    if (dbg_state !== IDLE) begin
      tests_failed++; $display("FAIL reset_state: got %0d expected %0d", dbg_state, IDLE);
    end
    @(posedge clk); #1; reset = 1'b1;
  endtask

  task automatic test_first_batch;
    int g0;
    g0 = go_cnt;
    drive_start(8'h10);
    wait_go(0);
    tests_run++;
    if (lane_nonce !== {32'd2, 32'd1, 32'd0}) begin
      tests_failed++; $display("FAIL t1_slices: got %0h expected 2/1/0", lane_nonce);
    end
    drive_batch(8'h40, 8'h05, 8'h03, 2, 4, 3);
    @(negedge clk);
    tests_run++;
    if (finished !== 1'b0 || dbg_state !== CHECK) begin
      tests_failed++; $display("FAIL t1_check_cycle: got fin=%0b state=%0d expected fin=0 state=%0d", finished, dbg_state, CHECK);
    end
    @(negedge clk);
    tests_run++;
    if (finished !== 1'b1 || nonce_out !== 32'd1) begin
      tests_failed++; $display("FAIL t1_result: got fin=%0b nonce=%0d expected fin=1 nonce=1", finished, nonce_out);
    end
    tests_run++;
    if (busy !== 1'b0 || exhausted !== 1'b0 || go_cnt - g0 !== 1) begin
      tests_failed++; $display("FAIL t1_flags: got busy=%0b exh=%0b gos=%0d expected 0/0/1", busy, exhausted, go_cnt - g0);
    end
  endtask

  task automatic test_multi_batch;
    int g0;
    g0 = go_cnt;
    drive_start(8'h10);
    wait_go(0);
    tests_run++;
    if (finished !== 1'b0 || busy !== 1'b1) begin
      tests_failed++; $display("FAIL t2_restart: got fin=%0b busy=%0b expected fin=0 busy=1", finished, busy);
    end
    drive_batch(8'hFF, 8'hFF, 8'hFF, 1, 2, 1);
    for (int b = 1; b < 3; b++) begin
      wait_go(0);
      drive_batch(8'hFF, 8'hFF, 8'hFF, 2, 1, 3);
    end
    wait_go(0);
    tests_run++;
    if (lane_nonce !== {32'd11, 32'd10, 32'd9}) begin
      tests_failed++; $display("FAIL t2_slices: got %0h expected 11/10/9", lane_nonce);
    end
    drive_batch(8'hFF, 8'hFF, 8'h00, 1, 1, 1);
    repeat (2) @(negedge clk);
    tests_run++;
    if (finished !== 1'b1 || nonce_out !== 32'd11 || go_cnt - g0 !== 4) begin
      tests_failed++; $display("FAIL t2_result: got fin=%0b nonce=%0d gos=%0d expected 1/11/4", finished, nonce_out, go_cnt - g0);
    end
  endtask

  task automatic test_duplicate_valid;
    drive_start(8'h10);
    wait_go(0);
    lane_hash = {8'hFF, 16'h0, 8'hFF, 16'h0, 8'hFF, 16'h0};
    @(posedge clk); #1; lane_valid = 3'b001;
    @(posedge clk); #1; lane_hash[23:16] = 8'h00; lane_valid = 3'b001;
    @(posedge clk); #1; lane_valid = 3'b110;
    @(posedge clk); #1; lane_valid = 3'b000;
    wait_go(0);
    tests_run++;
    if (finished !== 1'b0 || lane_nonce[31:0] !== 32'd3) begin
      tests_failed++; $display("FAIL t4_dup_ignored: got fin=%0b slice0=%0d expected fin=0 slice0=3", finished, lane_nonce[31:0]);
    end
  endtask

  // Continues from the base-3 go of the duplicate test: reset lands mid-WAIT.
  task automatic test_reset_and_busy_start;
    int g0;
    @(posedge clk); #1; lane_valid = 3'b001;
    @(posedge clk); #1; lane_valid = 3'b000;
    #2; reset = 1'b0;
    #1;
    tests_run++;
    if ({lane_nonce, lane_go, busy, finished, nonce_out, exhausted} !== '0 || dbg_state !== IDLE) begin
      tests_failed++; $display("FAIL t5_async_reset: got nonce=%0h busy=%0b state=%0d expected all 0 and IDLE",
                               lane_nonce, busy, dbg_state);
    end
    #2; reset = 1'b1;
    g0 = go_cnt;
    drive_start(8'h10);
    wait_go(0);
    tests_run++;
    if (lane_nonce !== {32'd2, 32'd1, 32'd0}) begin
      tests_failed++; $display("FAIL t5_restart_slices: got %0h expected 2/1/0", lane_nonce);
    end
    lane_hash = {8'hFF, 16'h0, 8'hFF, 16'h0, 8'hFF, 16'h0};
    @(posedge clk); #1; start = 1'b1; target = 8'h00; lane_valid = 3'b111;
    @(posedge clk); #1; start = 1'b0; lane_valid = 3'b000;
    wait_go(0);
    tests_run++;
    if (lane_nonce[31:0] !== 32'd3) begin
      tests_failed++; $display("FAIL t5_busy_start: got slice0=%0d expected 3", lane_nonce[31:0]);
    end
    drive_batch(8'hFF, 8'h02, 8'hFF, 1, 1, 1);
    repeat (2) @(negedge clk);
    tests_run++;
    if (finished !== 1'b1 || nonce_out !== 32'd4 || go_cnt - g0 !== 2) begin
      tests_failed++; $display("FAIL t5_result: got fin=%0b nonce=%0d gos=%0d expected 1/4/2", finished, nonce_out, go_cnt - g0);
    end
  endtask

  task automatic test_exhaust_small;
    int g0;
    g0 = go_cnt4;
    drive_start(8'h10);
    for (int b = 0; b < 5; b++) begin
      wait_go(1);
      drive_batch(8'hFF, 8'hFF, 8'hFF, 1, 1, 1);
    end
    wait_go(1);
    tests_run++;
    if (lane_nonce4 !== 12'h00F) begin
      tests_failed++; $display("FAIL t3_last_slices: got %0h expected 00f", lane_nonce4);
    end
    drive_batch(8'hFF, 8'hFF, 8'hFF, 1, 0, 0);
    repeat (2) @(negedge clk);
    tests_run++;
    if (exhausted4 !== 1'b1 || finished4 !== 1'b0 || busy4 !== 1'b0) begin
      tests_failed++; $display("FAIL t3_exhausted: got exh=%0b fin=%0b busy=%0b expected 1/0/0", exhausted4, finished4, busy4);
    end
    tests_run++;
    if (go_cnt4 - g0 !== 6) begin
      tests_failed++; $display("FAIL t3_go_count: got %0d expected 6", go_cnt4 - g0);
    end
  endtask

`ifdef LANE_TIMEOUT_EN
  task automatic test_timeout;
    @(posedge clk); #1; reset = 1'b0;
    @(posedge clk); #1; reset = 1'b1;
    drive_start(8'h10);
    wait_go(0);
    lane_hash = {8'h00, 16'h0, 8'hFF, 16'h0, 8'hFF, 16'h0};
    @(posedge clk); #1; lane_valid = 3'b011;
    @(posedge clk); #1; lane_valid = 3'b000;
    repeat (7) @(negedge clk);
    tests_run++;
    if (dbg_state !== WAIT || timeout_err !== 1'b0) begin
      tests_failed++; $display("FAIL t6_still_wait: got state=%0d terr=%0b expected %0d/0", dbg_state, timeout_err, WAIT);
    end
    @(negedge clk);
    tests_run++;
    if (dbg_state !== CHECK || timeout_err !== 1'b1) begin
      tests_failed++; $display("FAIL t6_forced_check: got state=%0d terr=%0b expected %0d/1", dbg_state, timeout_err, CHECK);
    end
    wait_go(0);
    tests_run++;
    if (lane_nonce[31:0] !== 32'd3 || finished !== 1'b0 || timeout_err !== 1'b1) begin
      tests_failed++; $display("FAIL t6_continue: got slice0=%0d fin=%0b terr=%0b expected 3/0/1",
                               lane_nonce[31:0], finished, timeout_err);
    end
  endtask
`endif

  initial begin
    reset = 1'b0; start = 1'b0; target = '0; lane_valid = '0; lane_hash = '0;
    test_reset();
    test_first_batch();
    test_multi_batch();
    test_duplicate_valid();
    test_reset_and_busy_start();
    test_exhaust_small();
`ifdef LANE_TIMEOUT_EN
    test_timeout();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/mining_lane_ctrl.md
Name: mining_lane_ctrl

Overview:
Parametrised N-lane nonce dispatcher and result collector for the micro-hash mining datapath. It partitions the nonce space across LANES parallel hash lanes by interleaving: lane i gets base+i, and the stride is LANES. It issues a synchronous go pulse per batch, gathers per-lane hash results, and compares each against the target. It reports the lowest winning nonce, or exhaustion of the nonce space.

Parameters:
LANES, 3, number of parallel hash lanes (>=1)
NONCE_W, 32, nonce width
HASH_W, 24, hash width per lane
TARGET_W, 8, target width; compared against hash MSBs

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
start  in  1  one-cycle pulse; begins a new search from nonce 0
target  in  TARGET_W  difficulty; sampled on start, held internally
lane_nonce  out  LANES*NONCE_W  nonce for lane i at slice i; stable from go until next go
lane_go  out  1  one-cycle pulse; lanes begin hashing lane_nonce
lane_valid  in  LANES  per-lane result strobe, one per go
lane_hash  in  LANES*HASH_W  per-lane hash, qualified by lane_valid[i]
busy  out  1  high in ISSUE/WAIT/CHECK
finished  out  1  winning nonce found; held until next start
nonce_out  out  NONCE_W  winning nonce; valid while finished
exhausted  out  1  nonce space searched without a hit; held until next start

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, base=0, masks=0, all outputs 0.
- Hit rule: lane i hits iff lane_hash[i][HASH_W-1 -: TARGET_W] < target_q. A target of 0 never hits.
- Lane enable: lane i is enabled iff base+i <= 2^NONCE_W-1, computed at NONCE_W+1 bits. Disabled lanes are pre-set in the done mask, their hits are ignored, and their lane_nonce slice is driven 0.
- FSM:
  - IDLE: start -> ISSUE; base<=0; target_q<=target.
  - ISSUE: lane_go=1 for exactly one cycle; done_mask<=~enable; hit_mask<=0; -> WAIT.
  - WAIT: each cycle, done_mask|=lane_valid and hit_mask|=lane_valid&hit. A lane_valid for an already-done lane is ignored, and its hit is not re-sampled. When the next done_mask is all ones -> CHECK.
  - CHECK: if hit_mask != 0, pick the lowest set index i (this is also the lowest nonce); nonce_out<=base+i; finished<=1; -> DONE. Else if base+LANES > 2^NONCE_W-1: exhausted<=1; -> EXHAUST. Else base<=base+LANES; -> ISSUE.
  - DONE / EXHAUST: outputs held. start -> same action as from IDLE, and finished/exhausted clear on that edge.
- start while busy is ignored.
- Latency: the edge sampling the final lane_valid moves to CHECK. finished/exhausted rise on the following edge. The first lane_go occurs in the cycle after start is sampled.
- lane_valid arriving in the same cycle as lane_go belongs to the new batch only if it arrives in WAIT; in ISSUE it is ignored.
- Reset mid-search returns to IDLE immediately; no outputs persist.

Optional Feature:
LANE_TIMEOUT_EN
- Defined: adds parameter TIMEOUT (default 64) and output timeout_err (1 bit).
  - A counter clears in ISSUE and increments in WAIT.
  - Reaching TIMEOUT-1 forces CHECK; unreported lanes count as no-hit.
  - timeout_err is sticky and clears on start or reset.
- Undefined: no counter, no port; WAIT waits indefinitely.

Decomposition:
- Shared package mining_pkg:
  - state enum (IDLE, ISSUE, WAIT, CHECK, DONE, EXHAUST)
  - default LANES/NONCE_W/HASH_W/TARGET_W constants
  - hit-compare function
- One sub-module, lane_prio_enc: LANES-bit mask -> lowest set index plus any-bit flag, purely combinational, parametrised on LANES.

Test Plan:
1. Defaults: start, target=8'h10; batch 0 lanes return hash MSBs 8'h40, 8'h05, 8'h03 in cycles 2, 4, 3 -> finished=1 and nonce_out=1, one cycle after CHECK; lane_go pulsed once.
2. Three batches with no hit (all MSBs 8'hFF), then batch base=9 with lane 2 MSB 8'h00 -> lane_nonce slices 9, 10, 11 during batch 4; nonce_out=11; 4 lane_go pulses.
3. NONCE_W=4, LANES=3, never hit -> bases 0,3,6,9,12,15. At base 15, lanes 1 and 2 are disabled with slices 0, and only lane 0's valid is needed -> exhausted=1; 6 go pulses; finished=0.
4. Duplicate lane_valid[0] with a hitting hash after a non-hit was already recorded -> ignored; no finish from lane 0.
5. reset=0 asserted in WAIT mid-batch -> all outputs 0 asynchronously; a later start begins at nonce 0; start during busy has no effect.
6. LANE_TIMEOUT_EN, TIMEOUT=8: lane 2 never responds -> CHECK after 8 WAIT cycles; timeout_err=1; search continues at base 3.
